// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_pkg;

    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 8;
    localparam int APB_NUM_REQ = 2;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Round-robin picker: one-hot winner, search starts just after the last grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(last_grant_i) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Multi-requester APB master: round-robin command acceptance, one APB transfer
// at a time, with an optional pready timeout reported through rsp_err.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int addrWidth = APB_ADDR_W,
    parameter int dataWidth = APB_DATA_W,
    parameter int NUM_REQ   = APB_NUM_REQ,
    parameter int TIMEOUT   = APB_TIMEOUT
) (
    input  logic                           pclk,
    input  logic                           prst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*addrWidth-1:0]   req_addr,
    input  logic [NUM_REQ*dataWidth-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic                           rsp_err,
    output logic [dataWidth-1:0]           rsp_rdata,
    output logic [addrWidth-1:0]           paddr,
    output logic                           pwrite,
    output logic                           psel,
    output logic                           pen,
    output logic [dataWidth-1:0]           pwdata,
    input  logic [dataWidth-1:0]           prdata,
    input  logic                           pready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    apb_state_e           state_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [NUM_REQ-1:0]   owner_q;
    logic [CNT_W-1:0]     tcnt_q;
    logic                 psel_q, pen_q, pwrite_q, rsp_err_q;
    logic [addrWidth-1:0] paddr_q;
    logic [dataWidth-1:0] pwdata_q, rsp_rdata_q;
    logic [NUM_REQ-1:0]   req_grant_q, rsp_valid_q;

    logic [NUM_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_write;
    logic [addrWidth-1:0] win_addr;
    logic [dataWidth-1:0] win_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (win_oh)
    );

    always_comb begin
        win_idx   = last_grant_q;
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx   = IDX_W'(i);
                win_write = req_write[i];
                win_addr  = req_addr[i*addrWidth +: addrWidth];
                win_wdata = req_wdata[i*dataWidth +: dataWidth];
            end
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            tcnt_q       <= '0;
            psel_q       <= 1'b0;
            pen_q        <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            req_grant_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            req_grant_q <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        last_grant_q <= win_idx;
                        owner_q      <= win_oh;
                        req_grant_q  <= win_oh;
                        pwrite_q     <= win_write;
                        paddr_q      <= win_addr;
                        pwdata_q     <= win_wdata;
                        psel_q       <= 1'b1;
                        pen_q        <= 1'b0;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    pen_q   <= 1'b1;
                    tcnt_q  <= '0;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q      <= 1'b0;
                        pen_q       <= 1'b0;
                        rsp_valid_q <= owner_q;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        state_q     <= IDLE;
                    end else if (TIMEOUT != 0 && tcnt_q == CNT_LAST) begin
                        // this edge is the TIMEOUT-th pready-low ACCESS cycle
                        psel_q      <= 1'b0;
                        pen_q       <= 1'b0;
                        rsp_valid_q <= owner_q;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= IDLE;
                    end else if (tcnt_q != '1) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_grant = req_grant_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign pen       = pen_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: APB slave memory with programmable wait states,
// transaction-level reference model, directed scenarios plus random traffic.
module tb_apb_master_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int N  = 2;
    localparam int TO = 16;
    localparam logic [N*AW-1:0] AMASK = {{(N-1)*AW{1'b0}}, {AW{1'b1}}};
    localparam logic [N*DW-1:0] DMASK = {{(N-1)*DW{1'b0}}, {DW{1'b1}}};

    logic            pclk = 1'b0;
    logic            prst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_grant, rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   paddr;
    logic            pwrite, psel, pen;
    logic [DW-1:0]   pwdata, prdata;
    logic            pready;

    apb_master_arbiter #(
        .addrWidth (AW),
        .dataWidth (DW),
        .NUM_REQ   (N),
        .TIMEOUT   (TO)
    ) dut (
        .pclk      (pclk),
        .prst      (prst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_grant (req_grant),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .pen       (pen),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    // APB slave: memory, pready after stall_n low ACCESS cycles
    logic [DW-1:0] mem [256] = '{default: 8'h00};
    int wait_cnt = 0;
    int stall_n  = 0;
    assign pready = (wait_cnt >= stall_n);
    assign prdata = mem[paddr];

    always @(posedge pclk) begin
        if (psel && pen) begin
            if (pready) begin
                if (pwrite) mem[paddr] <= pwdata;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // reference model state
    int errs = 0, checks = 0, cyc = 0;
    bit busy = 0;
    int last = N - 1;
    int cur = 0, g = 0, done_cyc = 0, cur_stall = 0, next_stall = 0;
    logic          cur_wr = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wd = '0;
    logic [DW-1:0] ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != 0;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int l);
        for (int k = 1; k <= N; k++)
            if (bitof(v, (l + k) % N)) return (l + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [N-1:0] m;
        m = N'(1) << i;
        req_valid = v ? (req_valid | m) : (req_valid & ~m);
        req_write = w ? (req_write | m) : (req_write & ~m);
        req_addr  = (req_addr  & ~(AMASK << (i*AW))) | ((N*AW)'(a) << (i*AW));
        req_wdata = (req_wdata & ~(DMASK << (i*DW))) | ((N*DW)'(d) << (i*DW));
    endtask

    // one clock: predict what the edge did from the inputs it saw, then compare
    task automatic step();
        logic [N-1:0]    pv, pw, eg, er;
        logic [N*AW-1:0] pa;
        logic [N*DW-1:0] pd;
        logic            ee;
        logic [DW-1:0]   erd;
        pv = req_valid; pw = req_write; pa = req_addr; pd = req_wdata;
        @(negedge pclk);
        cyc++;
        eg = '0; er = '0; ee = 1'b0; erd = '0;
        if (busy && cyc == done_cyc) begin
            er  = N'(1) << cur;
            ee  = (cur_stall >= TO);
            erd = (ee || cur_wr) ? '0 : ref_mem[cur_addr];
            if (!ee && cur_wr) ref_mem[cur_addr] = cur_wd;
            busy = 0;
        end else if (!busy && pv != '0) begin
            cur       = rr_pick(pv, last);
            last      = cur;
            eg        = N'(1) << cur;
            busy      = 1;
            g         = cyc;
            cur_wr    = bitof(pw, cur);
            cur_addr  = AW'(pa >> (cur*AW));
            cur_wd    = DW'(pd >> (cur*DW));
            cur_stall = next_stall;
            stall_n   = next_stall;
            done_cyc  = (cur_stall < TO) ? g + 2 + cur_stall : g + 1 + TO;
        end
        chk("req_grant", req_grant, eg);
        chk("rsp_valid", rsp_valid, er);
        if (er != '0) begin
            chk("rsp_err", rsp_err, ee);
            chk("rsp_rdata", rsp_rdata, erd);
        end
        if (busy) begin
            chk("psel", psel, 1);
            chk("pen", pen, cyc > g);
            chk("paddr", paddr, cur_addr);
            chk("pwrite", pwrite, cur_wr);
            chk("pwdata", pwdata, cur_wd);
        end else begin
            chk("psel_idle", psel, 0);
            chk("pen_idle", pen, 0);
        end
    endtask

    task automatic run_one(input int i, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int stall,
                           output int lg, output int lr, output int pcnt,
                           output logic err, output logic [DW-1:0] rd);
        int c0;
        bit done;
        set_req(i, 1, w, a, d);
        next_stall = stall;
        c0 = cyc; lg = -1; lr = -1; pcnt = 0; done = 0; err = 1'b0; rd = '0;
        for (int k = 0; k < 60 && !done; k++) begin
            step();
            if (bitof(req_grant, i)) begin
                lg = cyc - c0;
                set_req(i, 0, w, a, d);
            end
            if (pen) pcnt++;
            if (rsp_valid != '0) begin
                lr = cyc - c0; err = rsp_err; rd = rsp_rdata; done = 1;
            end
        end
        chk("run_completed", done, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: still running at cycle %0d, required finish before 30000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lg, lr, pcnt, prev_g, nwin, r;
        logic err;
        logic [DW-1:0] rd;
        int wins [4];

        for (int a = 0; a < 256; a++) ref_mem[a] = '0;

        // reset state
        repeat (3) @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_pen", pen, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_grant", req_grant, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        prst = 1'b0;

        // write then read back through the other requester
        run_one(0, 1, 8'h10, 8'hA5, 0, lg, lr, pcnt, err, rd);
        chk("wr_grant_latency", lg, 1);
        chk("wr_rsp_latency", lr, 3);
        chk("wr_err", err, 0);
        run_one(1, 0, 8'h10, 8'h00, 0, lg, lr, pcnt, err, rd);
        chk("rd_rsp_latency", lr, 3);
        chk("rd_rdata", rd, 8'hA5);

        // both requesters hold valid: alternating grants, 3-cycle period
        set_req(0, 1, 1, 8'h01, 8'h11);
        set_req(1, 1, 0, 8'h02, 8'h22);
        next_stall = 0;
        nwin = 0; prev_g = -1;
        for (int k = 0; k < 20 && nwin < 4; k++) begin
            step();
            if (req_grant != '0) begin
                wins[nwin] = bitof(req_grant, 1) ? 1 : 0;
                if (prev_g >= 0) chk("rr_period", cyc - prev_g, 3);
                prev_g = cyc;
                nwin++;
            end
        end
        req_valid = '0;
        chk("rr_grant_count", nwin, 4);
        for (int k = 0; k < 4; k++) chk("rr_order", wins[k], k % 2);
        for (int k = 0; k < 10 && busy; k++) step();

        // five wait states, below the timeout
        run_one(0, 1, 8'h20, 8'h3C, 5, lg, lr, pcnt, err, rd);
        chk("wait5_pen_cycles", pcnt, 6);
        chk("wait5_rsp_latency", lr, 8);
        chk("wait5_err", err, 0);

        // slave never ready: timeout
        run_one(1, 0, 8'h20, 8'h00, 100, lg, lr, pcnt, err, rd);
        chk("tmo_pen_cycles", pcnt, 16);
        chk("tmo_rsp_latency", lr, 18);
        chk("tmo_err", err, 1);
        chk("tmo_rdata", rd, 0);

        // reset in the middle of ACCESS
        set_req(0, 1, 1, 8'h03, 8'h77);
        next_stall = 100;
        step();
        set_req(0, 0, 1, 8'h03, 8'h77);
        step();
        #2 prst = 1'b1;
        #1;
        chk("abort_psel", psel, 0);
        chk("abort_pen", pen, 0);
        @(negedge pclk);
        cyc++;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_grant", req_grant, 0);
        busy = 0; last = N - 1; stall_n = 0; next_stall = 0;
        prst = 1'b0;
        set_req(0, 1, 0, 8'h03, 8'h00);
        set_req(1, 1, 0, 8'h04, 8'h00);
        step();
        chk("post_reset_grant", req_grant, 2'b01);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (bitof(req_grant, i)) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(i, 1, 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), DW'($urandom_range(255, 0)));
                    else
                        set_req(i, 0, 0, '0, '0);
                end else if (!bitof(req_valid, i)) begin
                    if ($urandom_range(2, 0) == 0)
                        set_req(i, 1, 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), DW'($urandom_range(255, 0)));
                end else if ($urandom_range(19, 0) == 0) begin
                    set_req(i, 0, 0, '0, '0);
                end
            end
            r = int'($urandom_range(19, 0));
            next_stall = (r < 12) ? 0 : (r < 16) ? int'($urandom_range(4, 1)) :
                         (r == 16) ? TO - 1 : (r == 17) ? TO : (r == 18) ? TO + 3 : 7;
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 40 && busy; k++) step();
        chk("drained", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 The parameters SHALL be:
- addrWidth, default 8, APB address width.
- dataWidth, default 8, APB data width.
- NUM_REQ, default 2, number of requesters.
- TIMEOUT, default 16, maximum number of pready-low ACCESS cycles; 0 disables the timeout.

REQ-002 The ports SHALL be (name, direction, width, meaning):
- pclk  in  1  sole clock, rising edge.
- prst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*addrWidth  per-requester address, requester i in slice i.
- req_wdata  in  NUM_REQ*dataWidth  per-requester write data.
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse when a command is accepted.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- rsp_rdata  out  dataWidth  read data, qualified by rsp_valid.
- paddr  out  addrWidth  APB address.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- pen  out  1  APB enable.
- pwdata  out  dataWidth  APB write data.
- prdata  in  dataWidth  APB read data.
- pready  in  1  APB ready.

Function
REQ-003 The block SHALL run a three-state FSM: IDLE, SETUP, ACCESS.
REQ-004 In IDLE with any req_valid high, the next edge SHALL select a winner, register its write/addr/wdata onto pwrite/paddr/pwdata, set psel=1 and pen=0, raise req_grant[winner] for exactly that SETUP cycle, and move to SETUP.
REQ-005 In IDLE with no req_valid high, the FSM SHALL stay in IDLE with psel=0 and pen=0.
REQ-006 SETUP SHALL always last one cycle, then move to ACCESS with pen=1; paddr, pwrite and pwdata SHALL remain stable from SETUP through the end of ACCESS.
REQ-007 At an ACCESS edge with pready=1, the block SHALL:
- drop psel and pen;
- return to IDLE;
- pulse rsp_valid[winner] for one cycle with rsp_err=0;
- set rsp_rdata to the sampled prdata for a read, or 0 for a write.
REQ-008 Minimum latency SHALL be 3 cycles from req_valid seen in IDLE to rsp_valid, and a new transfer SHALL NOT start earlier than the cycle after rsp_valid (IDLE is always visited between transfers).
REQ-009 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins the first tie.
REQ-010 A requester SHALL hold req_valid and its fields stable until it sees req_grant; req_valid deasserted before grant withdraws the request without any side effect.
REQ-011 A timeout counter SHALL count ACCESS cycles with pready=0. When it reaches TIMEOUT with pready still 0, the block SHALL drop psel/pen, pulse rsp_valid[winner] with rsp_err=1 and rsp_rdata=0, and return to IDLE.
REQ-012 With TIMEOUT=0 the block SHALL wait indefinitely for pready; the counter SHALL saturate and never wrap.
REQ-013 req_valid changes during SETUP or ACCESS SHALL NOT affect the current transfer.
REQ-014 pready SHALL be ignored outside ACCESS.

Reset
REQ-015 prst high SHALL immediately force:
- FSM to IDLE;
- psel, pen, pwrite, req_grant, rsp_valid and rsp_err to 0;
- paddr, pwdata, rsp_rdata and the timeout counter to 0;
- last_grant to NUM_REQ-1.
REQ-016 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid, and the requester SHALL be expected to reissue.

Structure
REQ-017 Package apb_pkg SHALL hold the FSM state typedef (IDLE/SETUP/ACCESS) and the default width constants.
REQ-018 Round-robin selection SHALL live in sub-module rr_arbiter (inputs: request vector, last_grant; output: one-hot winner), instantiated once.

Verification (bench pairs the block with the team's APB slave, pready tied 1, unless noted)
REQ-019 Requester 0 writes 0xA5 to addr 0x10, then requester 1 reads 0x10: expect req_grant[0] 1 cycle after req_valid, rsp_valid[0] 3 cycles after req_valid, then rsp_valid[1] with rsp_rdata=0xA5.
REQ-020 Both requesters hold req_valid continuously: grants alternate 0,1,0,1, each transfer spans SETUP+ACCESS plus 1 IDLE cycle.
REQ-021 Slave model holds pready=0 for 5 cycles, TIMEOUT=16: expect pen high for 6 cycles, paddr/pwdata stable, rsp_err=0.
REQ-022 pready held 0, TIMEOUT=16: expect psel/pen to drop after 16 ACCESS cycles, with rsp_valid and rsp_err=1 and rsp_rdata=0.
REQ-023 prst asserted mid-ACCESS: expect psel=pen=0 in the same cycle, no rsp_valid, and requester 0 winning the next tie.
